// File: rtl/ecc_secded_link_if.sv
// Bus bundle for the SECDED link stage: input handshake, output handshake and error statistics.
// The master drives words and out_ready; the slave is the link stage itself.
interface ecc_secded_link_if #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned CNT_W  = 16
);
   localparam int unsigned P  = (DATA_W <= 4)  ? 3 :
                                (DATA_W <= 11) ? 4 :
                                (DATA_W <= 26) ? 5 :
                                (DATA_W <= 57) ? 6 : 7;
   localparam int unsigned CW = DATA_W + P + 1;

   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;
   logic [CW-1:0]     inj_mask;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   logic              out_err_single;
   logic              out_err_double;
   logic [P-1:0]      out_syndrome;
   logic              cnt_clr;
   logic [CNT_W-1:0]  corr_count;
   logic [CNT_W-1:0]  uncorr_count;

   modport master (
      output in_valid, in_data, inj_mask, out_ready, cnt_clr,
      input  in_ready, out_valid, out_data, out_err_single, out_err_double, out_syndrome,
             corr_count, uncorr_count
   );

   modport slave (
      input  in_valid, in_data, inj_mask, out_ready, cnt_clr,
      output in_ready, out_valid, out_data, out_err_single, out_err_double, out_syndrome,
             corr_count, uncorr_count
   );
endinterface

// File: rtl/ecc_secded_link.sv
// SECDED link stage: encode + fault injection into a transfer register, then decode/correct
// into an output register with ready/valid backpressure and saturating error counters.
module ecc_secded_link #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned CNT_W  = 16
) (
   input logic               clk,
   input logic               rst_n,
   ecc_secded_link_if.slave  link_io
);
   localparam int unsigned P  = (DATA_W <= 4)  ? 3 :
                                (DATA_W <= 11) ? 4 :
                                (DATA_W <= 26) ? 5 :
                                (DATA_W <= 57) ? 6 : 7;
   localparam int unsigned CW = DATA_W + P + 1;

   // Data bits fill the non-power-of-two positions in ascending order.
   function automatic logic [CW-1:0] encode(input logic [DATA_W-1:0] d);
      logic [CW-1:0]     c;
      logic [DATA_W-1:0] rem;
      logic              par;
      c   = '0;
      rem = d;
      for (int i = 1; i < CW; i++) begin
         if ((i & (i - 1)) != 0) begin
            c[i] = rem[0];
            rem  = rem >> 1;
         end
      end
      for (int k = 0; k < P; k++) begin
         par = 1'b0;
         for (int i = 1; i < CW; i++) begin
            if (((i >> k) & 1) == 1) par = par ^ c[i];
         end
         c[1 << k] = par;
      end
      c[0] = ^c[CW-1:1];
      return c;
   endfunction

   function automatic logic [DATA_W-1:0] extract(input logic [CW-1:0] c);
      logic [DATA_W-1:0] d;
      d = '0;
      for (int i = 1; i < CW; i++) begin
         if ((i & (i - 1)) != 0) d = {c[i], d[DATA_W-1:1]};
      end
      return d;
   endfunction

   logic [CW-1:0]     s1_q, s1_d;
   logic              s1_valid_q, s1_valid_d;
   logic              out_valid_q, out_valid_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic              single_q, single_d;
   logic              double_q, double_d;
   logic [P-1:0]      syn_q, syn_d;
   logic [CNT_W-1:0]  corr_q, corr_d;
   logic [CNT_W-1:0]  uncorr_q, uncorr_d;

   logic          advance;
   logic          in_hs;
   logic          out_hs;
   logic [P-1:0]  dec_syn;
   logic          dec_mm;
   logic          dec_single;
   logic          dec_double;
   logic [CW-1:0] dec_fixed;

   assign advance = !out_valid_q || link_io.out_ready;
   assign in_hs   = link_io.in_valid && link_io.in_ready;
   assign out_hs  = out_valid_q && link_io.out_ready;

   always_comb begin
      dec_syn = '0;
      for (int i = 1; i < CW; i++) begin
         if (s1_q[i]) dec_syn = dec_syn ^ i[P-1:0];
      end
      dec_mm     = ^s1_q;
      // Syndrome 0 with a mismatch is the overall-parity bit itself.
      dec_single = dec_mm && (32'(dec_syn) < CW);
      dec_double = !dec_single && (dec_mm || (dec_syn != '0));
      dec_fixed  = dec_single ? (s1_q ^ (CW'(1) << dec_syn)) : s1_q;
   end

   always_comb begin
      s1_d        = s1_q;
      s1_valid_d  = s1_valid_q;
      out_valid_d = out_valid_q;
      data_d      = data_q;
      single_d    = single_q;
      double_d    = double_q;
      syn_d       = syn_q;
      if (in_hs) begin
         s1_d       = encode(link_io.in_data) ^ link_io.inj_mask;
         s1_valid_d = 1'b1;
      end else if (advance) begin
         s1_valid_d = 1'b0;
      end
      if (advance) begin
         out_valid_d = s1_valid_q;
         if (s1_valid_q) begin
            data_d   = extract(dec_fixed);
            single_d = dec_single;
            double_d = dec_double;
            syn_d    = dec_syn;
         end
      end
   end

   always_comb begin
      corr_d   = corr_q;
      uncorr_d = uncorr_q;
      if (link_io.cnt_clr) begin
         corr_d   = '0;
         uncorr_d = '0;
      end else if (out_hs) begin
         if (single_q && (corr_q != '1)) corr_d = corr_q + CNT_W'(1);
         if (double_q && (uncorr_q != '1)) uncorr_d = uncorr_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_q        <= '0;
         s1_valid_q  <= 1'b0;
         out_valid_q <= 1'b0;
         data_q      <= '0;
         single_q    <= 1'b0;
         double_q    <= 1'b0;
         syn_q       <= '0;
         corr_q      <= '0;
         uncorr_q    <= '0;
      end else begin
         s1_q        <= s1_d;
         s1_valid_q  <= s1_valid_d;
         out_valid_q <= out_valid_d;
         data_q      <= data_d;
         single_q    <= single_d;
         double_q    <= double_d;
         syn_q       <= syn_d;
         corr_q      <= corr_d;
         uncorr_q    <= uncorr_d;
      end
   end

   assign link_io.in_ready       = !s1_valid_q || advance;
   assign link_io.out_valid      = out_valid_q;
   assign link_io.out_data       = data_q;
   assign link_io.out_err_single = single_q;
   assign link_io.out_err_double = double_q;
   assign link_io.out_syndrome   = syn_q;
   assign link_io.corr_count     = corr_q;
   assign link_io.uncorr_count   = uncorr_q;
endmodule

// File: tb/tb_ecc_secded_link.sv
// Directed bench for ecc_secded_link at DATA_W=32, CNT_W=4 with hand-computed expectations.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_ecc_secded_link;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   total = 0;
   int   bad = 0;

   always #5 clk = ~clk;

   ecc_secded_link_if #(.DATA_W(32), .CNT_W(4)) bus ();

   ecc_secded_link #(.DATA_W(32), .CNT_W(4)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .link_io (bus)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [38:0] bitm(input int a);
      return 39'(1) << a;
   endfunction

   // One word through an otherwise empty pipeline with out_ready high.
   task automatic run_word(input string tag, input logic [31:0] d, input logic [38:0] m,
                           input logic [31:0] e_data, input logic e_sgl, input logic e_dbl,
                           input logic [5:0] e_syn, input logic [3:0] e_corr,
                           input logic [3:0] e_unc);
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      bus.inj_mask = m;
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.in_data  = '0;
      bus.inj_mask = '1;
      chk({tag, "_lat_ov0"}, 64'(bus.out_valid), 64'(0));
      @(negedge clk);
      chk({tag, "_ov"}, 64'(bus.out_valid), 64'(1));
      chk({tag, "_data"}, 64'(bus.out_data), 64'(e_data));
      chk({tag, "_sgl"}, 64'(bus.out_err_single), 64'(e_sgl));
      chk({tag, "_dbl"}, 64'(bus.out_err_double), 64'(e_dbl));
      chk({tag, "_syn"}, 64'(bus.out_syndrome), 64'(e_syn));
      @(negedge clk);
      chk({tag, "_corr"}, 64'(bus.corr_count), 64'(e_corr));
      chk({tag, "_unc"}, 64'(bus.uncorr_count), 64'(e_unc));
      chk({tag, "_ov_drop"}, 64'(bus.out_valid), 64'(0));
   endtask

   initial begin
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.inj_mask  = '0;
      bus.out_ready = 1'b1;
      bus.cnt_clr   = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_in_ready", 64'(bus.in_ready), 64'(1));
      chk("rst_ov", 64'(bus.out_valid), 64'(0));
      chk("rst_data", 64'(bus.out_data), 64'(0));
      chk("rst_syn", 64'(bus.out_syndrome), 64'(0));
      chk("rst_flags", 64'({bus.out_err_single, bus.out_err_double}), 64'(0));
      chk("rst_cnt", 64'({bus.corr_count, bus.uncorr_count}), 64'(0));
      rst_n = 1'b1;

      run_word("clean", 32'hDEADBEEF, '0, 32'hDEADBEEF, 1'b0, 1'b0, 6'd0, 4'd0, 4'd0);
      run_word("sgl_d0", 32'hDEADBEEF, bitm(3), 32'hDEADBEEF, 1'b1, 1'b0, 6'd3, 4'd1, 4'd0);
      run_word("dbl_35", 32'h0, bitm(3) | bitm(5), 32'h3, 1'b0, 1'b1, 6'd6, 4'd1, 4'd1);
      run_word("sgl_p0", 32'hDEADBEEF, bitm(0), 32'hDEADBEEF, 1'b1, 1'b0, 6'd0, 4'd2, 4'd1);
      // Position 38 carries data[31].
      run_word("sgl_top", 32'h12345678, bitm(38), 32'h12345678, 1'b1, 1'b0, 6'd38, 4'd3, 4'd1);
      // Three flips: parity mismatch with syndrome 39, beyond the codeword.
      run_word("dbl_oob", 32'h0, bitm(1) | bitm(6) | bitm(32), 32'h4, 1'b0, 1'b1, 6'd39,
               4'd3, 4'd2);

      // Backpressure: two buffered, third refused, then drained in order.
      @(negedge clk);
      bus.out_ready = 1'b0;
      bus.inj_mask  = '0;
      bus.in_valid  = 1'b1;
      bus.in_data   = 32'h1;
      @(negedge clk);
      chk("bp_rdy2", 64'(bus.in_ready), 64'(1));
      bus.in_data = 32'h2;
      @(negedge clk);
      chk("bp_rdy3", 64'(bus.in_ready), 64'(0));
      bus.in_data = 32'h3;
      repeat (2) begin
         @(negedge clk);
         chk("bp_hold_rdy", 64'(bus.in_ready), 64'(0));
         chk("bp_hold_data", 64'(bus.out_data), 64'(1));
         chk("bp_hold_ov", 64'(bus.out_valid), 64'(1));
      end
      bus.out_ready = 1'b1;
      #1;
      chk("bp_rdy_comb", 64'(bus.in_ready), 64'(1));
      chk("bp_out1", 64'(bus.out_data), 64'(1));
      @(negedge clk);
      bus.in_valid = 1'b0;
      chk("bp_out2", 64'(bus.out_data), 64'(2));
      @(negedge clk);
      chk("bp_out3", 64'(bus.out_data), 64'(3));
      chk("bp_out3_ov", 64'(bus.out_valid), 64'(1));
      @(negedge clk);
      chk("bp_empty", 64'(bus.out_valid), 64'(0));
      chk("bp_cnt", 64'({bus.corr_count, bus.uncorr_count}), 64'({4'd3, 4'd2}));

      // Saturation: 20 back-to-back single-error words.
      @(negedge clk);
      bus.in_valid = 1'b1;
      for (int i = 0; i < 20; i++) begin
         bus.in_data  = 32'(i);
         bus.inj_mask = bitm(3);
         @(negedge clk);
      end
      bus.in_valid = 1'b0;
      repeat (4) @(negedge clk);
      chk("sat_corr", 64'(bus.corr_count), 64'(15));
      chk("sat_unc", 64'(bus.uncorr_count), 64'(2));

      // Clear coincident with a double-error output handshake.
      bus.in_valid = 1'b1;
      bus.in_data  = 32'h0;
      bus.inj_mask = bitm(3) | bitm(5);
      @(negedge clk);
      bus.in_valid = 1'b0;
      @(negedge clk);
      chk("clr_dbl", 64'(bus.out_err_double), 64'(1));
      bus.cnt_clr = 1'b1;
      @(negedge clk);
      bus.cnt_clr = 1'b0;
      chk("clr_corr", 64'(bus.corr_count), 64'(0));
      chk("clr_unc", 64'(bus.uncorr_count), 64'(0));

      // Reset with two words buffered.
      bus.out_ready = 1'b0;
      bus.inj_mask  = '0;
      bus.in_valid  = 1'b1;
      bus.in_data   = 32'hA;
      @(negedge clk);
      bus.in_data = 32'hB;
      @(negedge clk);
      bus.in_valid = 1'b0;
      chk("mr_full_ov", 64'(bus.out_valid), 64'(1));
      chk("mr_full_rdy", 64'(bus.in_ready), 64'(0));
      #2 rst_n = 1'b0;
      #1;
      chk("mr_ov", 64'(bus.out_valid), 64'(0));
      chk("mr_rdy", 64'(bus.in_ready), 64'(1));
      chk("mr_data", 64'(bus.out_data), 64'(0));
      @(negedge clk);
      rst_n = 1'b1;
      bus.out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("mr_no_emit", 64'(bus.out_valid), 64'(0));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
